// File: rtl/pcie_rxcrdt_monitor.sv
// PCIe RX credit monitor: counts header/data credits of TLPs leaving the RX buffer
// and streams round-robin counter snapshots to the PCIe SS through an 8-deep FIFO.
module pcie_rxcrdt_monitor #(
  parameter int TDATA_WIDTH       = 512,
  parameter int HDR_WIDTH         = 256,
  parameter int BUFFER_DEPTH      = 512,
  parameter int BUFFER_SB_HEADERS = 0,
  parameter int CPL_HDR_INIT      = BUFFER_DEPTH / 2,
  parameter int CPL_DATA_INIT     = CPL_HDR_INIT * ((TDATA_WIDTH - (BUFFER_SB_HEADERS != 0 ? 0 : HDR_WIDTH)) / 128)
                                    + (BUFFER_DEPTH / 4) * (TDATA_WIDTH / 128),
  parameter int P_HDR_INIT        = CPL_HDR_INIT / 2,
  parameter int P_DATA_INIT       = CPL_DATA_INIT * 3 / 4,
  parameter int NP_HDR_INIT       = CPL_HDR_INIT / 2,
  parameter int NP_DATA_INIT      = CPL_DATA_INIT / 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpld_tvalid,
  input  logic                   cpld_tready,
  input  logic                   cpld_tlast,
  input  logic [TDATA_WIDTH-1:0] cpld_tdata,
  input  logic                   req_tvalid,
  input  logic                   req_tready,
  input  logic                   req_tlast,
  input  logic [TDATA_WIDTH-1:0] req_tdata,
  output logic                   rxcrdt_tvalid,
  input  logic                   rxcrdt_tready,
  output logic [18:0]            rxcrdt_tdata
);

  logic [7:0]  cpld_fmt, req_fmt;
  logic [10:0] cpld_crd, req_crd;
  logic        cpld_fire, req_fire, cpld_is_cpl, req_is_p;

  assign cpld_fmt    = cpld_tdata[31:24];
  assign req_fmt     = req_tdata[31:24];
  assign cpld_crd    = ({1'b0, cpld_tdata[9:0]} + 11'd3) >> 2;
  assign req_crd     = ({1'b0, req_tdata[9:0]} + 11'd3) >> 2;
  assign cpld_fire   = cpld_tvalid && cpld_tready;
  assign req_fire    = req_tvalid && req_tready;
  assign cpld_is_cpl = (cpld_fmt[4:0] == 5'b01010);
  // A memory request without payload is a read, which is non-posted.
  assign req_is_p    = (req_fmt[6] && req_fmt[4:0] == 5'b00000) || (req_fmt[4:3] == 2'b10);

  logic unused_bits;
  assign unused_bits = &{1'b0, cpld_tdata[TDATA_WIDTH-1:32], cpld_tdata[23:10],
                         req_tdata[TDATA_WIDTH-1:32], req_tdata[23:10],
                         cpld_fmt[7], cpld_fmt[5], req_fmt[7], req_fmt[5]};

  logic        cpld_sop, cpld_upd, cpl_h;
  logic [10:0] cpl_d;
  logic        req_sop, req_upd, p_h, np_h;
  logic [10:0] p_d, np_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cpld_sop <= 1'b1;
      cpld_upd <= 1'b0;
      cpl_h    <= 1'b0;
      cpl_d    <= '0;
    end else begin
      cpld_upd <= cpld_fire && cpld_tlast;
      if (cpld_fire) begin
        cpld_sop <= cpld_tlast;
        if (cpld_sop) begin
          cpl_h <= cpld_is_cpl;
          cpl_d <= (cpld_is_cpl && cpld_fmt[6]) ? cpld_crd : 11'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_sop <= 1'b1;
      req_upd <= 1'b0;
      p_h     <= 1'b0;
      p_d     <= '0;
      np_h    <= 1'b0;
      np_d    <= '0;
    end else begin
      req_upd <= req_fire && req_tlast;
      if (req_fire) begin
        req_sop <= req_tlast;
        if (req_sop) begin
          p_h  <= req_is_p;
          p_d  <= (req_is_p && req_fmt[6]) ? req_crd : 11'd0;
          np_h <= !req_is_p;
          np_d <= (!req_is_p && req_fmt[6]) ? req_crd : 11'd0;
        end
      end
    end
  end

  logic [15:0] cnt_ph, cnt_nph, cnt_cplh, cnt_pd, cnt_npd, cnt_cpld;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_ph   <= 16'(P_HDR_INIT);
      cnt_nph  <= 16'(NP_HDR_INIT);
      cnt_cplh <= 16'(CPL_HDR_INIT);
      cnt_pd   <= 16'(P_DATA_INIT);
      cnt_npd  <= 16'(NP_DATA_INIT);
      cnt_cpld <= 16'(CPL_DATA_INIT);
    end else begin
      if (cpld_upd) begin
        cnt_cplh <= cnt_cplh + 16'(cpl_h);
        cnt_cpld <= cnt_cpld + 16'(cpl_d);
      end
      if (req_upd) begin
        cnt_ph  <= cnt_ph + 16'(p_h);
        cnt_pd  <= cnt_pd + 16'(p_d);
        cnt_nph <= cnt_nph + 16'(np_h);
        cnt_npd <= cnt_npd + 16'(np_d);
      end
    end
  end

  logic [2:0]  idx, idx_next;
  logic [15:0] snap;

  assign idx_next = idx + ((idx[1:0] == 2'b10) ? 3'd2 : 3'd1);

  always_comb begin
    snap = '0;
    case (idx)
      3'd0:    snap = cnt_ph;
      3'd1:    snap = cnt_nph;
      3'd2:    snap = cnt_cplh;
      3'd4:    snap = cnt_pd;
      3'd5:    snap = cnt_npd;
      3'd6:    snap = cnt_cpld;
      default: snap = '0;
    endcase
  end

  logic [18:0] mem [8];
  logic [3:0]  wptr, rptr;
  logic        full, empty, wr_en, rd_en;

  assign empty = (wptr == rptr);
  assign full  = (wptr[2:0] == rptr[2:0]) && (wptr[3] != rptr[3]);
  // A full FIFO refuses the write even when the head is popped the same cycle.
  assign wr_en = !full;
  assign rd_en = !empty && rxcrdt_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      idx  <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + 4'd1;
        idx  <= idx_next;
      end
      if (rd_en) rptr <= rptr + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wptr[2:0]] <= {idx, snap};
  end

  assign rxcrdt_tvalid = !empty && !rst;
  assign rxcrdt_tdata  = mem[rptr[2:0]];

endmodule

// File: tb/tb_pcie_rxcrdt_monitor.sv
// Scoreboard bench for pcie_rxcrdt_monitor: a credit-ledger model predicts every
// snapshot word; a monitor pops and compares each word the DUT hands over.
module tb_pcie_rxcrdt_monitor;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpld_tvalid, cpld_tready, cpld_tlast;
  logic [511:0] cpld_tdata;
  logic         req_tvalid, req_tready, req_tlast;
  logic [511:0] req_tdata;
  logic         rxcrdt_tvalid, rxcrdt_tready;
  logic [18:0]  rxcrdt_tdata;

  int n_cmp = 0;
  int n_bad = 0;

  pcie_rxcrdt_monitor dut (
    .clk(clk), .rst(rst),
    .cpld_tvalid(cpld_tvalid), .cpld_tready(cpld_tready), .cpld_tlast(cpld_tlast), .cpld_tdata(cpld_tdata),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tlast(req_tlast), .req_tdata(req_tdata),
    .rxcrdt_tvalid(rxcrdt_tvalid), .rxcrdt_tready(rxcrdt_tready), .rxcrdt_tdata(rxcrdt_tdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Credit ledger: counters by type code, credits staged one cycle after tlast.
  int         m_cnt   [8];
  int         m_stage [8];
  int         c_delta [8];
  int         r_delta [8];
  int         m_idx   = 0;
  int         m_count = 0;
  bit         c_sop = 1'b1, r_sop = 1'b1;
  bit [18:0]  sb  [$];
  bit [18:0]  got [$];

  function automatic int hdr_code(input bit is_req, input logic [7:0] ft);
    if (!is_req) return (ft[4:0] == 5'b01010) ? 2 : -1;
    if ((ft[6] && ft[4:0] == 5'b00000) || ft[4:3] == 2'b10) return 0;
    return 1;
  endfunction

  function automatic int next_idx(input int i);
    case (i)
      2:       return 4;
      6:       return 0;
      default: return i + 1;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_cnt = '{128, 128, 256, 0, 768, 256, 1024, 0};
        foreach (m_stage[k]) m_stage[k] = 0;
        m_idx = 0; m_count = 0; c_sop = 1'b1; r_sop = 1'b1;
        sb.delete();
      end else begin
        automatic int wr = 0, rd = 0, h;
        if (m_count < 8) begin
          sb.push_back({3'(m_idx), 16'(m_cnt[m_idx])});
          wr = 1;
          m_idx = next_idx(m_idx);
        end
        rd = (m_count > 0 && rxcrdt_tready) ? 1 : 0;
        m_count += wr - rd;
        for (int k = 0; k < 8; k++) begin
          m_cnt[k] = (m_cnt[k] + m_stage[k]) % 65536;
          m_stage[k] = 0;
        end
        if (cpld_tvalid && cpld_tready) begin
          if (c_sop) begin
            foreach (c_delta[k]) c_delta[k] = 0;
            h = hdr_code(1'b0, cpld_tdata[31:24]);
            if (h >= 0) begin
              c_delta[h] = 1;
              if (cpld_tdata[30]) c_delta[h+4] = (int'(cpld_tdata[9:0]) + 3) / 4;
            end
          end
          c_sop = cpld_tlast;
          if (cpld_tlast) foreach (c_delta[k]) m_stage[k] += c_delta[k];
        end
        if (req_tvalid && req_tready) begin
          if (r_sop) begin
            foreach (r_delta[k]) r_delta[k] = 0;
            h = hdr_code(1'b1, req_tdata[31:24]);
            r_delta[h] = 1;
            if (req_tdata[30]) r_delta[h+4] = (int'(req_tdata[9:0]) + 3) / 4;
          end
          r_sop = req_tlast;
          if (req_tlast) foreach (r_delta[k]) m_stage[k] += r_delta[k];
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("tvalid", 32'(rxcrdt_tvalid), 32'((m_count > 0) && !rst));
      if (rxcrdt_tvalid === 1'b1 && rxcrdt_tready && !rst) begin
        got.push_back(rxcrdt_tdata);
        if (sb.size() == 0) check("sb_underflow", 32'(rxcrdt_tdata), 32'h7FFFF);
        else check("word", 32'(rxcrdt_tdata), 32'(sb.pop_front()));
      end
    end
  end

  task automatic check_first6(input string name);
    bit [18:0] seq [6] = '{19'h00080, 19'h10080, 19'h20100, 19'h40300, 19'h50100, 19'h60400};
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) check(name, 32'(got[i]), 32'(seq[i]));
      else check(name, 32'h0DEAD, 32'(seq[i]));
    end
  endtask

  task automatic check_last(input string name, input int t, input bit [18:0] exp);
    bit [18:0] w = 19'h7FFFF;
    for (int i = 0; i < got.size(); i++)
      if (int'(got[i][18:16]) == t) w = got[i];
    check(name, 32'(w), 32'(exp));
  endtask

  task automatic check_cont(input string name);
    int breaks = 0;
    for (int i = 1; i < got.size(); i++)
      if (int'(got[i][18:16]) != next_idx(int'(got[i-1][18:16]))) breaks++;
    check(name, 32'(breaks), 32'd0);
  endtask

  task automatic rand_data(output logic [511:0] d);
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
  endtask

  task automatic hdr_data(input logic [7:0] ft, input logic [9:0] len, output logic [511:0] d);
    rand_data(d);
    d[31:24] = ft;
    d[9:0]   = len;
  endtask

  task automatic send_pkt(input bit on_req, input logic [7:0] ft, input logic [9:0] len, input int beats);
    logic [511:0] d;
    for (int b = 0; b < beats; b++) begin
      if (b == 0) hdr_data(ft, len, d); else rand_data(d);
      if (on_req) begin
        req_tvalid = 1'b1; req_tready = 1'b1; req_tlast = (b == beats - 1); req_tdata = d;
      end else begin
        cpld_tvalid = 1'b1; cpld_tready = 1'b1; cpld_tlast = (b == beats - 1); cpld_tdata = d;
      end
      @(posedge clk); #1;
    end
    req_tvalid = 1'b0; cpld_tvalid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  bit [7:0] fts [10] = '{8'h4A, 8'h0A, 8'h60, 8'h40, 8'h20, 8'h00, 8'h30, 8'h70, 8'h44, 8'h04};

  initial begin
    logic [511:0] d;
    int c_rem = 0, r_rem = 0;
    bit c_first = 0, r_first = 0;
    logic [7:0] cft = 8'h0, rft = 8'h0;
    logic [9:0] clen = 10'd0, rlen = 10'd0;

    rst = 1'b1;
    cpld_tvalid = 0; cpld_tready = 0; cpld_tlast = 0; cpld_tdata = '0;
    req_tvalid = 0; req_tready = 0; req_tlast = 0; req_tdata = '0;
    rxcrdt_tready = 1'b0;
    cycles(3);
    rst = 1'b0; rxcrdt_tready = 1'b1;
    cycles(10);
    check_first6("reset_seq");

    got.delete();
    send_pkt(1'b0, 8'h4A, 10'd16, 1);
    cycles(20);
    check_last("cpld_cplh", 2, 19'h20101);
    check_last("cpld_cpld", 6, 19'h60404);

    got.delete();
    send_pkt(1'b1, 8'h60, 10'd5, 3);
    cycles(20);
    check_last("mwr_ph", 0, 19'h00081);
    check_last("mwr_pd", 4, 19'h40302);

    got.delete();
    send_pkt(1'b1, 8'h20, 10'd8, 1);
    cycles(20);
    check_last("mrd_nph", 1, 19'h10081);
    check_last("mrd_npd", 5, 19'h50100);
    check_last("mrd_ph", 0, 19'h00081);

    got.delete();
    send_pkt(1'b0, 8'h20, 10'd8, 1);
    cycles(20);
    check_last("mrd_cpl_h", 2, 19'h20101);
    check_last("mrd_cpl_d", 6, 19'h60404);

    got.delete();
    rxcrdt_tready = 1'b0;
    cycles(20);
    check("stall_no_pop", 32'(got.size()), 32'd0);
    rxcrdt_tready = 1'b1;
    cycles(30);
    check_cont("stall_order");

    hdr_data(8'h60, 10'd5, d);
    req_tvalid = 1'b1; req_tready = 1'b1; req_tlast = 1'b0; req_tdata = d;
    cycles(1);
    rand_data(d); req_tdata = d;
    cycles(1);
    rst = 1'b1; req_tvalid = 1'b0;
    got.delete();
    cycles(2);
    rst = 1'b0;
    cycles(10);
    check_first6("midpkt_reset");

    got.delete();
    repeat (3000) begin
      if (c_rem == 0 && $urandom_range(0, 3) == 0) begin
        c_rem = $urandom_range(1, 3); cft = fts[$urandom_range(0, 9)];
        clen = 10'($urandom_range(0, 1023)); c_first = 1'b1;
      end
      if (r_rem == 0 && $urandom_range(0, 3) == 0) begin
        r_rem = $urandom_range(1, 3); rft = fts[$urandom_range(0, 9)];
        rlen = 10'($urandom_range(0, 1023)); r_first = 1'b1;
      end
      if (c_first) hdr_data(cft, clen, d); else rand_data(d);
      cpld_tdata = d; cpld_tlast = (c_rem == 1);
      cpld_tvalid = (c_rem > 0) && ($urandom_range(0, 3) != 0);
      cpld_tready = ($urandom_range(0, 3) != 0);
      if (r_first) hdr_data(rft, rlen, d); else rand_data(d);
      req_tdata = d; req_tlast = (r_rem == 1);
      req_tvalid = (r_rem > 0) && ($urandom_range(0, 3) != 0);
      req_tready = ($urandom_range(0, 3) != 0);
      rxcrdt_tready = ($urandom_range(0, 4) != 0);
      @(posedge clk);
      if (cpld_tvalid && cpld_tready) begin c_rem--; c_first = 1'b0; end
      if (req_tvalid && req_tready) begin r_rem--; r_first = 1'b0; end
      #1;
    end
    cpld_tvalid = 1'b0; req_tvalid = 1'b0; rxcrdt_tready = 1'b1;
    cycles(20);
    check_cont("random_order");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pcie_rxcrdt_monitor.md
# pcie_rxcrdt_monitor

Single-clock PCIe RX credit monitor that observes the completion and request TLP streams leaving the RX buffer and returns consumed credits to the PCIe SS. It keeps six free-running 16-bit credit counters (PH, NPH, CPLH, PD, NPD, CPLD) and continuously streams snapshots of them, round-robin, through an internal 8-entry FIFO. It sits between the RX TLP shims and the PCIe SS `rxcrdt` port; any clock crossing is outside this block.

## Interface
- `TDATA_WIDTH`, 512, data bus width in bits.
- `HDR_WIDTH`, 256, in-band header width in bits.
- `BUFFER_DEPTH`, 512, entries in each upstream buffer.
- `BUFFER_SB_HEADERS`, 0, 1 = upstream buffer keeps headers side-band.
- Derived values (not overridable):
  - `DCRD_NOHDR` = TDATA_WIDTH/128.
  - `DCRD_HDR` = (TDATA_WIDTH − (BUFFER_SB_HEADERS ? 0 : HDR_WIDTH))/128.
- Credit initial-value parameters:
  - `CPL_HDR_INIT`, BUFFER_DEPTH/2.
  - `CPL_DATA_INIT`, CPL_HDR_INIT·DCRD_HDR + (BUFFER_DEPTH/4)·DCRD_NOHDR.
  - `P_HDR_INIT`, CPL_HDR_INIT/2.
  - `P_DATA_INIT`, CPL_DATA_INIT·3/4.
  - `NP_HDR_INIT`, CPL_HDR_INIT/2.
  - `NP_DATA_INIT`, CPL_DATA_INIT/4.
- Ports:
  - `clk` in 1: the single clock.
  - `rst` in 1: synchronous, active-high reset.
  - `cpld_tvalid`, `cpld_tready`, `cpld_tlast` in 1 each: monitored completion stream handshake.
  - `cpld_tdata` in TDATA_WIDTH: completion data; header in-band, SOP at bit 0.
  - `req_tvalid`, `req_tready`, `req_tlast` in 1 each: monitored P/NP request stream handshake.
  - `req_tdata` in TDATA_WIDTH: request data, same header format.
  - `rxcrdt_tvalid` out 1: credit word valid.
  - `rxcrdt_tready` in 1: consumer accepts the word.
  - `rxcrdt_tdata` out 19: {type[2:0], count[15:0]}.

## Operation
- Both TLP streams are observe-only; the block never drives their `tready`.
- Header fields, taken from the first beat: `fmt_type` = tdata[31:24], `length` = tdata[9:0].
- Header classification:
  - Completion: fmt_type[4:0]==5'b01010.
  - Has data: fmt_type[6]==1.
  - MWr: fmt_type[4:0]==5'b00000.
  - Message: fmt_type[4:3]==2'b10.
- Data credits = (length + 3) >> 2, computed at 11 bits. length 0 yields 0 credits.
- Per stream, a `sop` flag starts at 1. On every accepted beat, `sop` ← tlast.
- On an accepted SOP beat, latch the pending update:
  - cpld stream: completion → H=1, D=credits if has data, else 0. Any other type → H=0, D=0.
  - req stream: MWr or Msg → P update (PH=1, PD=credits if has data). Anything else → NP update (NPH=1, NPD=credits if has data). Unused fields are 0.
- On an accepted tlast beat, pulse the stream's update-valid next cycle. Single-beat packets (SOP and tlast together) are legal.
- The update is added to the counters on the cycle after update-valid. Counters are 16-bit and wrap modulo 2^16.
- Type codes: PH=0, NPH=1, CPLH=2, PD=4, NPD=5, CPLD=6. Codes 3 and 7 are never emitted.
- Snapshot index: `idx` cycles 0,1,2,4,5,6,0,…
  - Next index: idx + (idx[1:0]==2'b10 ? 2 : 1).
  - Advances only on cycles when the FIFO is not full.
- FIFO write:
  - Written each cycle while not full and not in reset.
  - Write data = {idx, cnt[idx]}, sampled that cycle.
  - A full FIFO blocks the write even if a read occurs the same cycle.
- FIFO read: show-ahead, 8 × 19 bits.
  - `rxcrdt_tvalid` = !empty.
  - `rxcrdt_tdata` = head entry.
  - Pop on tvalid && tready.
- Index order is never skipped: after backpressure, the stream resumes at the index after the last written entry.

## Timing
- During reset and the cycle it is applied:
  - Counters load their INIT values.
  - idx=0, sop=1, update-valids=0, FIFO empty.
  - `rxcrdt_tvalid`=0; `rxcrdt_tdata` don't-care.
- First cycle after reset deassertion: entry {0,PH} written.
- Cycle after that: `rxcrdt_tvalid`=1 with {0,PH}.
- Update latency: tlast accepted at cycle N → update-valid at N+1 → counter new value at N+2. The earliest snapshot showing it is written at N+2.
- cpld and req updates in the same cycle both apply; they touch disjoint counters.
- Reset mid-packet discards the partial packet and its pending update.

## Test plan
- Reset, then `rxcrdt_tready`=1. Required `rxcrdt_tdata` sequence: 0x00080, 0x10080, 0x20100, 0x40300, 0x50100, 0x60400, then repeat.
- Single-beat CplD, fmt_type 0x4A, length 16 → CPLH 256→257 and CPLD 1024→1028. Snapshot with idx 6 reads 0x60404.
- 3-beat MWr, fmt_type 0x60, length 5 → PH 129 and PD 770. Counters are unchanged until 2 cycles after tlast.
- MRd, fmt_type 0x20, length 8, on req → NPH 129, NPD unchanged 256. The same MRd header on cpld → no counter change.
- `rxcrdt_tready`=0 for 20 cycles → exactly 8 entries buffered, idx frozen. On release, 8 entries drain in order and the sequence continues without a gap.
- Assert `rst` mid-packet with counters modified → all counters return to INIT values and the output restarts at 0x00080.
